// File: rtl/pipe_mips32_fwd.sv
// Five-stage MIPS32-subset core with EX-stage forwarding, load-use interlock,
// EX-resolved BEQZ/BNEQZ with IF/ID+ID/EX flush, HLT and a retire counter.
module pipe_mips32_fwd #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int IMEM_DEPTH = 1024,
  parameter int DMEM_DEPTH = 1024,
  parameter int FWD_EN     = 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] pc,
  output logic            halted,
  output logic [31:0]     instret
);

  localparam int RW  = (NREG > 1) ? $clog2(NREG) : 1;
  localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  typedef enum logic [2:0] {K_NOP, K_ALU, K_LW, K_SW, K_BEQZ, K_BNEQZ, K_HLT} kind_e;
  typedef enum logic [2:0] {A_ADD, A_SUB, A_AND, A_OR, A_SLT} alu_e;

  typedef struct packed {
    logic            valid;
    kind_e           kind;
    alu_e            alu;
    logic            use_imm;
    logic [RW-1:0]   rs;
    logic [RW-1:0]   rt;
    logic [RW-1:0]   dst;
    logic            we;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] npc;
  } idex_t;

  typedef struct packed {
    logic            valid;
    kind_e           kind;
    logic [RW-1:0]   dst;
    logic            we;
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] sd;
  } exmem_t;

  typedef struct packed {
    logic            valid;
    logic            is_hlt;
    logic [RW-1:0]   dst;
    logic            we;
    logic [XLEN-1:0] res;
  } memwb_t;

  logic [XLEN-1:0] Reg     [NREG];
  logic [31:0]     ProgMem [IMEM_DEPTH];
  logic [XLEN-1:0] DataMem [DMEM_DEPTH];

  logic            if_valid;
  logic [31:0]     if_ir;
  logic [XLEN-1:0] if_npc;
  logic            fetch_stop;
  idex_t           id_ex;
  exmem_t          ex_mem;
  memwb_t          mem_wb;

  // ---------------- ID: decode and register read ----------------
  logic [5:0]      id_op;
  logic [RW-1:0]   id_rs, id_rt, id_rd, id_dst;
  logic [XLEN-1:0] id_imm, id_a, id_b;
  kind_e           id_kind;
  alu_e            id_alu;
  logic            id_use_imm, id_use_rs, id_use_rt, id_we;
  logic            wb_write;

  assign wb_write = mem_wb.we && !halted;

  // NOTE: every always_comb output gets a default before the case so no latch is inferred.
  always_comb begin
    id_op      = if_ir[31:26];
    id_rs      = if_ir[21 +: RW];
    id_rt      = if_ir[16 +: RW];
    id_rd      = if_ir[11 +: RW];
    id_imm     = {{(XLEN-16){if_ir[15]}}, if_ir[15:0]};
    id_kind    = K_NOP;
    id_alu     = A_ADD;
    id_use_imm = 1'b0;
    id_use_rs  = 1'b0;
    id_use_rt  = 1'b0;
    id_dst     = id_rd;
    id_we      = 1'b0;
    case (id_op)
      6'b000000: begin id_kind = K_ALU; id_alu = A_ADD; id_use_rs = 1'b1; id_use_rt = 1'b1; id_we = 1'b1; end
      6'b000001: begin id_kind = K_ALU; id_alu = A_SUB; id_use_rs = 1'b1; id_use_rt = 1'b1; id_we = 1'b1; end
      6'b000010: begin id_kind = K_ALU; id_alu = A_AND; id_use_rs = 1'b1; id_use_rt = 1'b1; id_we = 1'b1; end
      6'b000011: begin id_kind = K_ALU; id_alu = A_OR;  id_use_rs = 1'b1; id_use_rt = 1'b1; id_we = 1'b1; end
      6'b000100: begin id_kind = K_ALU; id_alu = A_SLT; id_use_rs = 1'b1; id_use_rt = 1'b1; id_we = 1'b1; end
      6'b001010: begin id_kind = K_ALU; id_alu = A_ADD; id_use_imm = 1'b1; id_use_rs = 1'b1; id_dst = id_rt; id_we = 1'b1; end
      6'b001011: begin id_kind = K_ALU; id_alu = A_SUB; id_use_imm = 1'b1; id_use_rs = 1'b1; id_dst = id_rt; id_we = 1'b1; end
      6'b001100: begin id_kind = K_ALU; id_alu = A_SLT; id_use_imm = 1'b1; id_use_rs = 1'b1; id_dst = id_rt; id_we = 1'b1; end
      6'b001000: begin id_kind = K_LW; id_use_imm = 1'b1; id_use_rs = 1'b1; id_dst = id_rt; id_we = 1'b1; end
      6'b001001: begin id_kind = K_SW; id_use_imm = 1'b1; id_use_rs = 1'b1; id_use_rt = 1'b1; end
      6'b001101: begin id_kind = K_BNEQZ; id_use_rs = 1'b1; end
      6'b001110: begin id_kind = K_BEQZ;  id_use_rs = 1'b1; end
      6'b111111: id_kind = K_HLT;
      default:   id_kind = K_NOP;
    endcase
    if (!if_valid) begin
      id_kind   = K_NOP;
      id_we     = 1'b0;
      id_use_rs = 1'b0;
      id_use_rt = 1'b0;
    end
    // R0 is neither a real destination nor a real hazard source.
    if (id_dst == '0) id_we     = 1'b0;
    if (id_rs == '0)  id_use_rs = 1'b0;
    if (id_rt == '0)  id_use_rt = 1'b0;
  end

  // Register read sees the value being written back in the same cycle.
  always_comb begin
    id_a = '0;
    id_b = '0;
    if (id_rs != '0) id_a = (wb_write && mem_wb.dst == id_rs) ? mem_wb.res : Reg[id_rs];
    if (id_rt != '0) id_b = (wb_write && mem_wb.dst == id_rt) ? mem_wb.res : Reg[id_rt];
  end

  // ---------------- hazard detection ----------------
  logic lu_hit, raw_hit, stall, hlt_in_id;

  always_comb begin
    lu_hit  = (id_ex.kind == K_LW) && id_ex.we &&
              ((id_use_rs && id_rs == id_ex.dst) || (id_use_rt && id_rt == id_ex.dst));
    raw_hit = (id_ex.we  && ((id_use_rs && id_rs == id_ex.dst)  || (id_use_rt && id_rt == id_ex.dst))) ||
              (ex_mem.we && ((id_use_rs && id_rs == ex_mem.dst) || (id_use_rt && id_rt == ex_mem.dst)));
    stall   = (FWD_EN != 0) ? lu_hit : raw_hit;
  end

  assign hlt_in_id = (id_kind == K_HLT);

  // ---------------- EX: forwarding, ALU, branch ----------------
  logic [XLEN-1:0] ex_a, ex_b, ex_opb, ex_res, ex_target;
  logic            taken;

  always_comb begin
    ex_a = id_ex.a;
    ex_b = id_ex.b;
    if (FWD_EN != 0) begin
      if (ex_mem.we && ex_mem.dst == id_ex.rs)      ex_a = ex_mem.res;
      else if (mem_wb.we && mem_wb.dst == id_ex.rs) ex_a = mem_wb.res;
      if (ex_mem.we && ex_mem.dst == id_ex.rt)      ex_b = ex_mem.res;
      else if (mem_wb.we && mem_wb.dst == id_ex.rt) ex_b = mem_wb.res;
    end
    ex_opb = id_ex.use_imm ? id_ex.imm : ex_b;
    case (id_ex.alu)
      A_SUB:   ex_res = ex_a - ex_opb;
      A_AND:   ex_res = ex_a & ex_opb;
      A_OR:    ex_res = ex_a | ex_opb;
      A_SLT:   ex_res = {{(XLEN-1){1'b0}}, $signed(ex_a) < $signed(ex_opb)};
      default: ex_res = ex_a + ex_opb;
    endcase
    taken     = id_ex.valid && ((id_ex.kind == K_BEQZ  && ex_a == '0) ||
                                (id_ex.kind == K_BNEQZ && ex_a != '0));
    ex_target = id_ex.npc + id_ex.imm;
  end

  // ---------------- MEM ----------------
  logic [DAW-1:0]  d_idx;
  logic [IAW-1:0]  f_idx;
  logic [XLEN-1:0] mem_res;
  logic            dmem_write;

  assign f_idx      = IAW'(pc % XLEN'(IMEM_DEPTH));
  assign d_idx      = DAW'(ex_mem.res % XLEN'(DMEM_DEPTH));
  assign mem_res    = (ex_mem.kind == K_LW) ? DataMem[d_idx] : ex_mem.res;
  assign dmem_write = ex_mem.valid && (ex_mem.kind == K_SW) && !halted;

  // NOTE: Reg/ProgMem/DataMem have no reset so they map onto RAM and stay preloadable.
  always_ff @(posedge clk) begin
    if (!reset && wb_write)   Reg[mem_wb.dst] <= mem_wb.res;
    if (!reset && dmem_write) DataMem[d_idx]  <= ex_mem.sd;
  end

  // ---------------- pipeline registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= '0;
      halted     <= 1'b0;
      instret    <= '0;
      fetch_stop <= 1'b0;
      if_valid   <= 1'b0;
      if_ir      <= '0;
      if_npc     <= '0;
      id_ex      <= '0;
      ex_mem     <= '0;
      mem_wb     <= '0;
    end else begin
      // A taken branch outranks a stall: the stalled instruction is on the wrong path.
      if (taken) begin
        pc       <= ex_target;
        if_valid <= 1'b0;
      end else if (stall) begin
        pc       <= pc;
      end else if (hlt_in_id || fetch_stop || halted) begin
        if_valid <= 1'b0;
      end else begin
        pc       <= pc + 1'b1;
        if_valid <= 1'b1;
        if_ir    <= ProgMem[f_idx];
        if_npc   <= pc + 1'b1;
      end

      if (taken || stall) id_ex <= '0;
      else id_ex <= '{valid: if_valid, kind: id_kind, alu: id_alu, use_imm: id_use_imm,
                      rs: id_rs, rt: id_rt, dst: id_dst, we: id_we,
                      a: id_a, b: id_b, imm: id_imm, npc: if_npc};

      if (!taken && hlt_in_id) fetch_stop <= 1'b1;

      ex_mem <= '{valid: id_ex.valid, kind: id_ex.kind, dst: id_ex.dst, we: id_ex.we,
                  res: ex_res, sd: ex_b};
      mem_wb <= '{valid: ex_mem.valid, is_hlt: ex_mem.kind == K_HLT, dst: ex_mem.dst,
                  we: ex_mem.we, res: mem_res};

      if (mem_wb.valid && !halted)  instret <= instret + 1'b1;
      if (mem_wb.valid && mem_wb.is_hlt) halted <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_mips32_fwd.sv
// Directed bench for pipe_mips32_fwd: one forwarding core and one interlock-only
// core run the same hand-assembled programs side by side.
module tb_pipe_mips32_fwd;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_f, pc_n, instret_f, instret_n;
  logic        halted_f, halted_n;
  int          checks = 0;
  int          failures = 0;
  int          hc_f, hc_n;
  logic [31:0] prog [8];

  localparam logic [31:0] HLT = 32'hFC00_0000;

  pipe_mips32_fwd #(.FWD_EN(1)) dut_f (
    .clk(clk), .reset(reset), .pc(pc_f), .halted(halted_f), .instret(instret_f));
  pipe_mips32_fwd #(.FWD_EN(0)) dut_n (
    .clk(clk), .reset(reset), .pc(pc_n), .halted(halted_n), .instret(instret_n));

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_r(logic [5:0] op, int rs, int rt, int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // Holds reset, preloads Reg[k]=k and the program into both cores; leaves reset asserted.
  task automatic load_prog();
    reset = 1'b1;
    for (int k = 0; k < 32; k++) begin
      dut_f.Reg[k] = 32'(k);
      dut_n.Reg[k] = 32'(k);
    end
    for (int k = 0; k < 8; k++) begin
      dut_f.ProgMem[k] = prog[k];
      dut_n.ProgMem[k] = prog[k];
    end
    dut_f.DataMem[11] = 32'd0;
    dut_n.DataMem[11] = 32'd0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Cycle k is the k-th rising edge after reset release; -1 means no halt within 100.
  task automatic run_to_halt();
    hc_f = -1;
    hc_n = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (halted_f && hc_f < 0) hc_f = c;
      if (halted_n && hc_n < 0) hc_n = c;
      if (hc_f >= 0 && hc_n >= 0) break;
    end
  endtask

  task automatic set_prog1();
    prog = '{enc_r(6'b000000, 2, 3, 1), enc_r(6'b000000, 1, 1, 4),
             enc_r(6'b000001, 4, 2, 5), HLT, HLT, HLT, HLT, HLT};
  endtask

  task automatic set_prog2();
    prog = '{enc_i(6'b001001, 11, 12, 0), enc_i(6'b001000, 11, 13, 0),
             enc_i(6'b001010, 13, 14, 1), HLT, HLT, HLT, HLT, HLT};
  endtask

  task automatic test_reset();
    set_prog1();
    load_prog();
    checks++; if (pc_f !== 32'd0)      begin failures++; $display("FAIL reset_pc: got %0d want 0", pc_f); end
    checks++; if (halted_f !== 1'b0)   begin failures++; $display("FAIL reset_halted: got %0b want 0", halted_f); end
    checks++; if (instret_f !== 32'd0) begin failures++; $display("FAIL reset_instret: got %0d want 0", instret_f); end
    checks++; if (pc_n !== 32'd0)      begin failures++; $display("FAIL reset_pc_nofwd: got %0d want 0", pc_n); end
  endtask

  task automatic test_raw_chain();
    int ridx[3] = '{1, 4, 5};
    int rexp[3] = '{5, 10, 8};
    set_prog1();
    load_prog();
    reset = 1'b0;
    run_to_halt();
    checks++; if (hc_f !== 8) begin failures++; $display("FAIL raw_halt_cycle: got %0d want 8", hc_f); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dut_f.Reg[ridx[i]] !== 32'(rexp[i])) begin
        failures++; $display("FAIL raw_R%0d: got %0d want %0d", ridx[i], dut_f.Reg[ridx[i]], rexp[i]);
      end
    end
    checks++; if (instret_f !== 32'd4) begin failures++; $display("FAIL raw_instret: got %0d want 4", instret_f); end
    checks++; if (pc_f !== 32'd4)      begin failures++; $display("FAIL raw_pc: got %0d want 4", pc_f); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pc_f !== 32'd4)      begin failures++; $display("FAIL halt_pc_frozen: got %0d want 4", pc_f); end
    checks++; if (instret_f !== 32'd4) begin failures++; $display("FAIL halt_instret_frozen: got %0d want 4", instret_f); end
    checks++; if (halted_f !== 1'b1)   begin failures++; $display("FAIL halt_sticky: got %0b want 1", halted_f); end
  endtask

  task automatic test_load_use();
    set_prog2();
    load_prog();
    reset = 1'b0;
    run_to_halt();
    checks++; if (hc_f !== 9) begin failures++; $display("FAIL lu_halt_cycle: got %0d want 9", hc_f); end
    checks++; if (dut_f.DataMem[11] !== 32'd12) begin failures++; $display("FAIL lu_mem11: got %0d want 12", dut_f.DataMem[11]); end
    checks++; if (dut_f.Reg[13] !== 32'd12) begin failures++; $display("FAIL lu_R13: got %0d want 12", dut_f.Reg[13]); end
    checks++; if (dut_f.Reg[14] !== 32'd13) begin failures++; $display("FAIL lu_R14: got %0d want 13", dut_f.Reg[14]); end
    checks++; if (instret_f !== 32'd4) begin failures++; $display("FAIL lu_instret: got %0d want 4", instret_f); end
  endtask

  task automatic test_branch_taken();
    prog = '{enc_i(6'b001110, 0, 0, 2), enc_i(6'b001010, 0, 20, 99), enc_i(6'b001010, 0, 21, 99),
             enc_i(6'b001010, 0, 22, 7), HLT, HLT, HLT, HLT};
    load_prog();
    reset = 1'b0;
    run_to_halt();
    checks++; if (dut_f.Reg[20] !== 32'd20) begin failures++; $display("FAIL br_R20: got %0d want 20", dut_f.Reg[20]); end
    checks++; if (dut_f.Reg[21] !== 32'd21) begin failures++; $display("FAIL br_R21: got %0d want 21", dut_f.Reg[21]); end
    checks++; if (dut_f.Reg[22] !== 32'd7)  begin failures++; $display("FAIL br_R22: got %0d want 7", dut_f.Reg[22]); end
    checks++; if (instret_f !== 32'd3)      begin failures++; $display("FAIL br_instret: got %0d want 3", instret_f); end
    checks++; if (hc_f !== 9)               begin failures++; $display("FAIL br_halt_cycle: got %0d want 9", hc_f); end
    checks++; if (pc_f !== 32'd5)           begin failures++; $display("FAIL br_pc: got %0d want 5", pc_f); end
  endtask

  task automatic test_branch_not_taken();
    prog = '{enc_i(6'b001101, 0, 0, 5), enc_i(6'b001010, 8, 7, 10), HLT, HLT, HLT, HLT, HLT, HLT};
    load_prog();
    reset = 1'b0;
    run_to_halt();
    checks++; if (dut_f.Reg[7] !== 32'd18) begin failures++; $display("FAIL nt_R7: got %0d want 18", dut_f.Reg[7]); end
    checks++; if (instret_f !== 32'd3)     begin failures++; $display("FAIL nt_instret: got %0d want 3", instret_f); end
    checks++; if (hc_f !== 7)              begin failures++; $display("FAIL nt_halt_cycle: got %0d want 7", hc_f); end
  endtask

  task automatic test_no_forwarding();
    set_prog1();
    load_prog();
    reset = 1'b0;
    run_to_halt();
    checks++; if (dut_n.Reg[1] !== 32'd5)  begin failures++; $display("FAIL nf_R1: got %0d want 5", dut_n.Reg[1]); end
    checks++; if (dut_n.Reg[4] !== 32'd10) begin failures++; $display("FAIL nf_R4: got %0d want 10", dut_n.Reg[4]); end
    checks++; if (dut_n.Reg[5] !== 32'd8)  begin failures++; $display("FAIL nf_R5: got %0d want 8", dut_n.Reg[5]); end
    checks++; if (hc_n !== 12)             begin failures++; $display("FAIL nf_raw_halt_cycle: got %0d want 12", hc_n); end
    set_prog2();
    load_prog();
    reset = 1'b0;
    run_to_halt();
    checks++; if (dut_n.DataMem[11] !== 32'd12) begin failures++; $display("FAIL nf_mem11: got %0d want 12", dut_n.DataMem[11]); end
    checks++; if (dut_n.Reg[14] !== 32'd13)     begin failures++; $display("FAIL nf_R14: got %0d want 13", dut_n.Reg[14]); end
    checks++; if (hc_n !== 10)                  begin failures++; $display("FAIL nf_lu_halt_cycle: got %0d want 10", hc_n); end
    checks++; if (instret_n !== 32'd4)          begin failures++; $display("FAIL nf_instret: got %0d want 4", instret_n); end
  endtask

  task automatic test_reset_mid();
    set_prog1();
    load_prog();
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (instret_f !== 32'd1)    begin failures++; $display("FAIL mid_instret_before: got %0d want 1", instret_f); end
    checks++; if (dut_f.Reg[1] !== 32'd5) begin failures++; $display("FAIL mid_R1_before: got %0d want 5", dut_f.Reg[1]); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (pc_f !== 32'd0)         begin failures++; $display("FAIL mid_pc: got %0d want 0", pc_f); end
    checks++; if (instret_f !== 32'd0)    begin failures++; $display("FAIL mid_instret: got %0d want 0", instret_f); end
    checks++; if (halted_f !== 1'b0)      begin failures++; $display("FAIL mid_halted: got %0b want 0", halted_f); end
    checks++; if (dut_f.Reg[4] !== 32'd4) begin failures++; $display("FAIL mid_no_wb: got %0d want 4", dut_f.Reg[4]); end
    run_to_halt();
    checks++; if (hc_f !== 8)              begin failures++; $display("FAIL mid_rerun_halt: got %0d want 8", hc_f); end
    checks++; if (dut_f.Reg[4] !== 32'd10) begin failures++; $display("FAIL mid_rerun_R4: got %0d want 10", dut_f.Reg[4]); end
    checks++; if (dut_f.Reg[5] !== 32'd8)  begin failures++; $display("FAIL mid_rerun_R5: got %0d want 8", dut_f.Reg[5]); end
    checks++; if (instret_f !== 32'd4)     begin failures++; $display("FAIL mid_rerun_instret: got %0d want 4", instret_f); end
  endtask

  initial begin
    test_reset();
    test_raw_chain();
    test_load_use();
    test_branch_taken();
    test_branch_not_taken();
    test_no_forwarding();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
